// File: rtl/mrc_arbiter.sv
// ---------------------------------------------------------------------------
// mrc_arbiter
//
// Shares one multiply / square-root (MRC) unit between two requesters.
// A round-robin arbiter picks a requester, its operands are captured, and
// the FSM walks the MRC handshake (start, load a, optionally load b, wait
// for ready). The result is registered and the granted requester gets a
// one-cycle done pulse.
//
// Optional feature (macro MRC_ARB_TIMEOUT_EN):
//   When defined, each wait state (WAIT_X, WAIT_Y, WAIT_RDY) is bounded by
//   TIMEOUT cycles. On expiry the operation finishes with res_error=1 and
//   timeout=1, leaving res_data unchanged. When undefined, waits are
//   unbounded and timeout is tied low.
//
// Ports:
//   clk, reset           - single clock, asynchronous active-low reset
//   req0/op0/a0/b0       - requester 0 request, op (0=mul, 1=sqrt), operands
//   done0                - requester 0 completion pulse
//   req1/op1/a1/b1/done1 - requester 1, same meaning
//   res_data, res_error  - result of the last completed operation
//   timeout              - last operation ended by wait timeout
//   busy                 - arbiter is not idle
//   mrc_start/mrc_load/mrc_data/mrc_op - commands to the MRC unit
//   mrc_x/mrc_y/mrc_ready/mrc_result/mrc_error - status from the MRC unit
// ---------------------------------------------------------------------------
module mrc_arbiter #(
    parameter int WORD_LENGTH = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0,
    input  logic                     op0,
    input  logic [WORD_LENGTH-1:0]   a0,
    input  logic [WORD_LENGTH-1:0]   b0,
    output logic                     done0,

    input  logic                     req1,
    input  logic                     op1,
    input  logic [WORD_LENGTH-1:0]   a1,
    input  logic [WORD_LENGTH-1:0]   b1,
    output logic                     done1,

    output logic [2*WORD_LENGTH-1:0] res_data,
    output logic                     res_error,
    output logic                     timeout,
    output logic                     busy,

    output logic                     mrc_start,
    output logic                     mrc_load,
    output logic [WORD_LENGTH-1:0]   mrc_data,
    output logic                     mrc_op,

    input  logic                     mrc_x,
    input  logic                     mrc_y,
    input  logic                     mrc_ready,
    input  logic [2*WORD_LENGTH-1:0] mrc_result,
    input  logic                     mrc_error
);

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        START,
        WAIT_X,
        LOAD_X,
        WAIT_Y,
        LOAD_Y,
        WAIT_RDY,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic                   grant_id;
    logic                   grant_pick;
    logic                   last_served;
    logic                   op_q;
    logic [WORD_LENGTH-1:0] a_q;
    logic [WORD_LENGTH-1:0] b_q;

    logic                   wait_expired;
    logic                   timeout_exit;

    // Round-robin choice: when both request, favour the one not served
    // last; a lone request always wins.
    assign grant_pick = (req0 && req1) ? ~last_served : req1;

`ifdef MRC_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Any state change clears the counter, so it starts from zero on entry
    // to every wait state and counts cycles spent there. It never needs to
    // exceed TIMEOUT-1 because expiry leaves the wait state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Timeout flag is sticky until the next operation is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (state == GRANT) begin
            timeout <= 1'b0;
        end else if (timeout_exit) begin
            timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign wait_expired       = 1'b0;
    assign timeout            = 1'b0;
`endif

    // State register plus the datapath registers the FSM controls: grant
    // selection, operand capture, result capture and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant_id    <= 1'b0;
            last_served <= 1'b1;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_data    <= '0;
            res_error   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && (req0 || req1)) begin
                grant_id <= grant_pick;
            end

            if (state == GRANT) begin
                op_q <= grant_id ? op1 : op0;
                a_q  <= grant_id ? a1  : a0;
                b_q  <= grant_id ? b1  : b0;
            end

            if (state == WAIT_RDY && mrc_ready) begin
                res_data  <= mrc_result;
                res_error <= mrc_error;
            end else if (timeout_exit) begin
                res_error <= 1'b1;
            end

            // DONE is only ever entered from another state, so this fires
            // exactly once per operation.
            if (state_nxt == DONE) begin
                last_served <= grant_id;
            end
        end
    end

    // Next-state and output decode. Outputs are pure state decodes so an
    // asserted reset zeroes them immediately through the state register.
    always_comb begin
        state_nxt    = state;
        timeout_exit = 1'b0;
        busy         = 1'b1;
        done0        = 1'b0;
        done1        = 1'b0;
        mrc_start    = 1'b0;
        mrc_load     = 1'b0;
        mrc_data     = '0;
        mrc_op       = op_q;

        case (state)
            IDLE: begin
                busy   = 1'b0;
                mrc_op = 1'b0;
                if (req0 || req1) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                mrc_op    = 1'b0;
                state_nxt = START;
            end
            START: begin
                mrc_start = 1'b1;
                state_nxt = WAIT_X;
            end
            WAIT_X: begin
                if (mrc_x) begin
                    state_nxt = LOAD_X;
                end else if (wait_expired) begin
                    state_nxt    = DONE;
                    timeout_exit = 1'b1;
                end
            end
            LOAD_X: begin
                mrc_load  = 1'b1;
                mrc_data  = a_q;
                // Square root takes a single operand.
                state_nxt = op_q ? WAIT_RDY : WAIT_Y;
            end
            WAIT_Y: begin
                if (mrc_y) begin
                    state_nxt = LOAD_Y;
                end else if (wait_expired) begin
                    state_nxt    = DONE;
                    timeout_exit = 1'b1;
                end
            end
            LOAD_Y: begin
                mrc_load  = 1'b1;
                mrc_data  = b_q;
                state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (mrc_ready) begin
                    state_nxt = DONE;
                end else if (wait_expired) begin
                    state_nxt    = DONE;
                    timeout_exit = 1'b1;
                end
            end
            DONE: begin
                done0     = ~grant_id;
                done1     = grant_id;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                mrc_op    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mrc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mrc_arbiter
//
// Directed bench for mrc_arbiter. The MRC unit is played by hand from the
// bench: handshake inputs are driven on the falling edge and outputs are
// sampled on the falling edge, one step at a time.
// ---------------------------------------------------------------------------
module tb_mrc_arbiter;

    localparam int WL = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0, op0, req1, op1;
    logic [WL-1:0]   a0, b0, a1, b1;
    logic            done0, done1;
    logic [2*WL-1:0] res_data;
    logic            res_error, timeout, busy;
    logic            mrc_start, mrc_load, mrc_op;
    logic [WL-1:0]   mrc_data;
    logic            mrc_x, mrc_y, mrc_ready, mrc_error;
    logic [2*WL-1:0] mrc_result;

    int checks   = 0;
    int failures = 0;

    mrc_arbiter #(
        .WORD_LENGTH (WL),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .op0        (op0),
        .a0         (a0),
        .b0         (b0),
        .done0      (done0),
        .req1       (req1),
        .op1        (op1),
        .a1         (a1),
        .b1         (b1),
        .done1      (done1),
        .res_data   (res_data),
        .res_error  (res_error),
        .timeout    (timeout),
        .busy       (busy),
        .mrc_start  (mrc_start),
        .mrc_load   (mrc_load),
        .mrc_data   (mrc_data),
        .mrc_op     (mrc_op),
        .mrc_x      (mrc_x),
        .mrc_y      (mrc_y),
        .mrc_ready  (mrc_ready),
        .mrc_result (mrc_result),
        .mrc_error  (mrc_error)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, returning on the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic o0,
                                 input logic [WL-1:0] av0, input logic [WL-1:0] bv0,
                                 input logic r1, input logic o1,
                                 input logic [WL-1:0] av1, input logic [WL-1:0] bv1);
        req0 = r0; op0 = o0; a0 = av0; b0 = bv0;
        req1 = r1; op1 = o1; a1 = av1; b1 = bv1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full multiply from IDLE back to IDLE, with the MRC answering
    // each handshake one cycle after the arbiter starts waiting for it.
    task automatic runMulOp(input logic [1:0] exp_done, input logic [WL-1:0] exp_a,
                            input logic [WL-1:0] exp_b, input logic [2*WL-1:0] result);
        tick(1);
        tick(1);
        checkOutput("rr_start", 64'(mrc_start), 64'd1);
        mrc_x = 1'b1;
        tick(2);
        checkOutput("rr_load_a", 64'({mrc_load, mrc_data}), 64'({1'b1, exp_a}));
        mrc_x = 1'b0;
        mrc_y = 1'b1;
        tick(2);
        checkOutput("rr_load_b", 64'({mrc_load, mrc_data}), 64'({1'b1, exp_b}));
        mrc_y      = 1'b0;
        mrc_ready  = 1'b1;
        mrc_result = result;
        tick(2);
        checkOutput("rr_done", 64'({done1, done0}), 64'(exp_done));
        checkOutput("rr_result", 64'(res_data), 64'(result));
        mrc_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        mrc_x      = 1'b0;
        mrc_y      = 1'b0;
        mrc_ready  = 1'b0;
        mrc_error  = 1'b0;
        mrc_result = '0;
        @(negedge clk);
        tick(2);

        // Reset state: every output low.
        checkOutput("reset_ctrl", 64'({busy, done0, done1, mrc_start, mrc_load,
                                       mrc_op, res_error, timeout}), 64'd0);
        checkOutput("reset_data", 64'({res_data, mrc_data}), 64'd0);

        reset = 1'b1;
        tick(1);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        // Multiply 3*5 on requester 0; request drops after grant,
        // operands change after capture, stray y/ready are ignored.
        applyStimulus(1, 0, 3, 5, 0, 0, 0, 0);
        tick(1);
        checkOutput("grant_busy", 64'({busy, mrc_start}), 64'b10);
        applyStimulus(0, 0, 3, 5, 0, 0, 0, 0);
        tick(1);
        checkOutput("latency_start", 64'({mrc_start, mrc_op}), 64'b10);
        applyStimulus(0, 0, 77, 88, 0, 0, 0, 0);
        mrc_y     = 1'b1;
        mrc_ready = 1'b1;
        tick(1);
        checkOutput("start_one_cycle", 64'({mrc_start, mrc_load, mrc_data}), 64'd0);
        tick(1);
        checkOutput("wait_x_ignores", 64'({busy, mrc_load, done0, done1}), 64'b1000);
        mrc_y     = 1'b0;
        mrc_ready = 1'b0;
        mrc_x     = 1'b1;
        tick(1);
        checkOutput("load_a", 64'({mrc_load, mrc_data}), 64'({1'b1, 16'd3}));
        mrc_x = 1'b0;
        tick(1);
        checkOutput("wait_y_quiet", 64'({mrc_load, mrc_data}), 64'd0);
        mrc_y = 1'b1;
        tick(1);
        checkOutput("load_b", 64'({mrc_load, mrc_data}), 64'({1'b1, 16'd5}));
        mrc_y = 1'b0;
        tick(1);
        checkOutput("wait_rdy_quiet", 64'(mrc_load), 64'd0);
        mrc_ready  = 1'b1;
        mrc_result = 32'd15;
        tick(1);
        checkOutput("mul_done", 64'({done1, done0, res_error, mrc_op}), 64'b0100);
        checkOutput("mul_result", 64'(res_data), 64'd15);
        mrc_ready  = 1'b0;
        mrc_result = 32'hdead;
        tick(1);
        checkOutput("mul_idle", 64'({busy, done1, done0}), 64'd0);
        checkOutput("mul_hold", 64'(res_data), 64'd15);

        // Square root of 16 on requester 1 with an error flag.
        applyStimulus(0, 0, 0, 0, 1, 1, 16, 7);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 1, 16, 7);
        tick(1);
        checkOutput("sqrt_start", 64'({mrc_start, mrc_op}), 64'b11);
        mrc_x = 1'b1;
        tick(2);
        checkOutput("sqrt_load", 64'({mrc_load, mrc_data}), 64'({1'b1, 16'd16}));
        mrc_x = 1'b0;
        tick(1);
        checkOutput("sqrt_no_y", 64'({busy, mrc_load, mrc_data}), 64'({1'b1, 1'b0, 16'd0}));
        mrc_ready  = 1'b1;
        mrc_result = 32'd4;
        mrc_error  = 1'b1;
        tick(1);
        checkOutput("sqrt_done", 64'({done1, done0, res_error}), 64'b101);
        checkOutput("sqrt_result", 64'(res_data), 64'd4);
        mrc_ready = 1'b0;
        mrc_error = 1'b0;
        tick(1);

        // Round-robin with both requests held after a fresh reset.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        applyStimulus(1, 0, 10, 11, 1, 0, 20, 21);
        runMulOp(2'b01, 10, 11, 100);
        runMulOp(2'b10, 20, 21, 101);
        runMulOp(2'b01, 10, 11, 102);
        runMulOp(2'b10, 20, 21, 103);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        checkOutput("rr_release", 64'(busy), 64'd0);

        // Reset asserted in WAIT_RDY abandons the operation.
        applyStimulus(1, 1, 9, 0, 0, 0, 0, 0);
        tick(1);
        applyStimulus(0, 1, 9, 0, 0, 0, 0, 0);
        tick(1);
        mrc_x = 1'b1;
        tick(2);
        mrc_x = 1'b0;
        tick(1);
        checkOutput("pre_reset_busy", 64'({busy, mrc_op}), 64'b11);
        reset = 1'b0;
        #1;
        checkOutput("async_ctrl", 64'({busy, done0, done1, mrc_start, mrc_load,
                                       mrc_op, res_error, timeout}), 64'd0);
        checkOutput("async_data", 64'({res_data, mrc_data}), 64'd0);
        mrc_ready  = 1'b1;
        mrc_result = 32'd55;
        tick(1);
        checkOutput("reset_no_done", 64'({busy, done0, done1, res_data}), 64'd0);
        reset     = 1'b1;
        mrc_ready = 1'b0;
        applyStimulus(1, 0, 2, 6, 0, 0, 0, 0);
        runMulOp(2'b01, 2, 6, 12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Requester 0 waits for an mrc_x that never comes.
        applyStimulus(1, 0, 4, 4, 0, 0, 0, 0);
        tick(1);
        applyStimulus(0, 0, 4, 4, 0, 0, 0, 0);
        tick(2);
        tick(TO - 1);
        checkOutput("wait_x_pending", 64'({busy, done0, timeout}), 64'b100);
        tick(1);
`ifdef MRC_ARB_TIMEOUT_EN
        checkOutput("to_done", 64'({done0, done1, timeout, res_error}), 64'b1011);
        checkOutput("to_data_kept", 64'(res_data), 64'd12);
        tick(1);
        checkOutput("to_sticky", 64'({busy, timeout}), 64'b01);
        applyStimulus(0, 0, 0, 0, 1, 1, 25, 0);
        tick(2);
        checkOutput("to_cleared", 64'({mrc_start, timeout}), 64'b10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`else
        checkOutput("no_to_waiting", 64'({busy, done0, timeout, res_error}), 64'b1000);
        tick(300);
        checkOutput("no_to_forever", 64'({busy, done0, done1, timeout, mrc_load}), 64'b10000);
`endif
        reset = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mrc_arbiter.md
MRC_ARBITER -- requirements
Module: mrc_arbiter

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, operand width matching the shared MRC unit.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per wait state (used only under REQ-032).
REQ-003 SHALL have ports, clock and reset first: clk input 1, the single clock; reset input 1, asynchronous, active-low.
REQ-004 SHALL have requester 0 ports: req0 input 1, op0 input 1 (0=multiply, 1=square root), a0 input WORD_LENGTH, b0 input WORD_LENGTH, done0 output 1.
REQ-005 SHALL have requester 1 ports: req1, op1, a1, b1, done1, with the same directions and widths as requester 0.
REQ-006 SHALL have shared result ports: res_data output 2*WORD_LENGTH, res_error output 1, timeout output 1, busy output 1.
REQ-007 SHALL have MRC-side outputs: mrc_start 1, mrc_load 1, mrc_data WORD_LENGTH, mrc_op 1.
REQ-008 SHALL have MRC-side inputs: mrc_x 1, mrc_y 1, mrc_ready 1, mrc_result 2*WORD_LENGTH, mrc_error 1.

Function
REQ-009 SHALL use states IDLE, GRANT, START, WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, WAIT_RDY, DONE.
REQ-010 In IDLE with any reqN high, SHALL go to GRANT next cycle; otherwise SHALL stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; a single request SHALL be granted regardless of history.
REQ-012 The last-served pointer SHALL update only on entry to DONE.
REQ-013 GRANT SHALL capture the granted op, a and b into internal registers; later operand changes SHALL be ignored.
REQ-014 GRANT→START unconditionally; mrc_start SHALL be high for exactly the one START cycle, with mrc_op driven from the captured op in every state from START to DONE inclusive.
REQ-015 START→WAIT_X; WAIT_X→LOAD_X when mrc_x is sampled high.
REQ-016 In LOAD_X, mrc_data SHALL be the captured a and mrc_load SHALL be high for exactly one cycle.
REQ-017 LOAD_X→WAIT_Y if op=0; LOAD_X→WAIT_RDY if op=1, so square root loads a single operand.
REQ-018 WAIT_Y→LOAD_Y on mrc_y high; LOAD_Y SHALL drive mrc_data with the captured b and a one-cycle mrc_load, then go to WAIT_RDY.
REQ-019 WAIT_RDY→DONE on mrc_ready high; in that same edge, mrc_result SHALL be registered into res_data and mrc_error into res_error.
REQ-020 In DONE, doneN of the granted requester SHALL be high for exactly one cycle; the other done SHALL stay low; DONE→IDLE.
REQ-021 res_data and res_error SHALL hold their values until the next DONE.
REQ-022 busy SHALL be low only in IDLE.
REQ-023 mrc_data SHALL be 0 outside LOAD_X and LOAD_Y.
REQ-024 A reqN that drops after GRANT SHALL NOT abort the operation; the operation completes and doneN still pulses.
REQ-025 A requester holding reqN high through DONE SHALL be treated as a new request in IDLE, subject to round-robin.
REQ-026 Minimum latency SHALL be: req sampled at edge k gives mrc_start high in cycle k+2.
REQ-027 mrc_x, mrc_y and mrc_ready asserted in states that do not wait for them SHALL be ignored.

Reset
REQ-028 reset low SHALL asynchronously force state to IDLE and the pointer to favour requester 0.
REQ-029 reset low SHALL clear all captured registers and clear every output to 0: res_data, res_error, timeout, busy, done0, done1, mrc_start, mrc_load, mrc_data, mrc_op.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-031 After reset deasserts, the block SHALL start from IDLE on the first clk edge.

Configuration
REQ-032 Macro MRC_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_X, WAIT_Y and WAIT_RDY and increment each cycle spent in those states.
REQ-033 With MRC_ARB_TIMEOUT_EN defined, on reaching TIMEOUT the block SHALL go to DONE with res_error=1, timeout=1, res_data unchanged and a normal doneN pulse.
REQ-034 With MRC_ARB_TIMEOUT_EN defined, timeout SHALL clear at the next GRANT.
REQ-035 Macro MRC_ARB_TIMEOUT_EN undefined: no counter is built, timeout SHALL be tied 0 and waits SHALL be unbounded.

Verification
REQ-036 req0=1, op0=0, a0=3, b0=5; model asserts x, then y, then ready with result 15 → one mrc_start pulse, mrc_load with data 3 then 5, res_data=15, done0 pulse, done1 stays 0.
REQ-037 req1=1, op1=1, a1=16; model returns 4 → exactly one mrc_load (data 16), no wait for y, res_data=4, done1 pulse.
REQ-038 req0 and req1 both held high after reset → grant order 0,1,0,1 across four completed operations.
REQ-039 reset driven low during WAIT_RDY → all outputs 0 immediately with no done; after release, a new req0 completes normally.
REQ-040 MRC_ARB_TIMEOUT_EN with TIMEOUT=8, mrc_x never asserted → DONE reached 8 cycles after entering WAIT_X, timeout=1, res_error=1, done pulse; without the macro the block stays in WAIT_X indefinitely.
